rom_access_sequencer: RTL and testbench



---
 rtl/rom_access_sequencer_pkg.sv | 25 ++
 rtl/rom_access_sequencer_if.sv | 47 ++++
 rtl/rom_access_sequencer_pending_slot.sv | 60 ++++++
 rtl/rom_access_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_rom_access_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/rom_access_sequencer_pkg.sv
// Shared types and constants for the cartridge ROM/SRAM access sequencer.
package rom_access_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SRD,
    SWR,
    MRD,
    MWR,
    REC
  } state_t;

  localparam int RD_CYCLES_DEF      = 5;
  localparam int WR_CYCLES_DEF      = 4;
  localparam int RECOVER_CYCLES_DEF = 1;

  // Byte address bit 0 picks the lane: even bytes live on DQ[15:8], odd on DQ[7:0].
  localparam logic LANE_HIGH = 1'b0;
  localparam logic LANE_LOW  = 1'b1;

  function automatic logic [7:0] lane_byte(input logic lane, input logic [15:0] dq);
    return (lane == LANE_LOW) ? dq[7:0] : dq[15:8];
  endfunction

endpackage

// File: rtl/rom_access_sequencer_if.sv
// Bus bundle between the SNES/MCU front ends, the sequencer and the memory pads.
interface rom_access_sequencer_if;

  logic        snes_rd_start;
  logic        snes_wr_start;
  logic [23:0] rom_addr;
  logic        rom_hit;
  logic        is_writable;
  logic [7:0]  snes_din;
  logic [7:0]  snes_dout;
  logic        snes_dout_valid;
  logic        snes_ovr;

  logic        mcu_rrq;
  logic        mcu_wrq;
  logic [23:0] mcu_addr;
  logic [7:0]  mcu_dout;
  logic [7:0]  mcu_din;
  logic        mcu_rdy;

  logic [22:0] mem_addr;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic        mem_bhe_n;
  logic        mem_ble_n;
  logic [15:0] mem_dq_out;
  logic        mem_dq_oe;
  logic [15:0] mem_dq_in;

  modport master (
    output snes_rd_start, snes_wr_start, rom_addr, rom_hit, is_writable, snes_din,
    output mcu_rrq, mcu_wrq, mcu_addr, mcu_dout, mem_dq_in,
    input  snes_dout, snes_dout_valid, snes_ovr, mcu_din, mcu_rdy,
    input  mem_addr, mem_ce_n, mem_oe_n, mem_we_n, mem_bhe_n, mem_ble_n,
    input  mem_dq_out, mem_dq_oe
  );

  modport slave (
    input  snes_rd_start, snes_wr_start, rom_addr, rom_hit, is_writable, snes_din,
    input  mcu_rrq, mcu_wrq, mcu_addr, mcu_dout, mem_dq_in,
    output snes_dout, snes_dout_valid, snes_ovr, mcu_din, mcu_rdy,
    output mem_addr, mem_ce_n, mem_oe_n, mem_we_n, mem_bhe_n, mem_ble_n,
    output mem_dq_out, mem_dq_oe
  );

endinterface

// File: rtl/rom_access_sequencer_pending_slot.sv
// One-deep SNES request latch. Filters start pulses on hit/writable, holds one
// request until the sequencer consumes it, and flags an overwrite of a request
// that was never served. A pulse arriving while the slot is empty and being
// consumed bypasses the latch so an idle sequencer can start on the next edge.
module rom_access_sequencer_pending_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_start,
  input  logic        wr_start,
  input  logic [23:0] addr,
  input  logic [7:0]  din,
  input  logic        rom_hit,
  input  logic        is_writable,
  input  logic        consume,
  output logic        req_valid,
  output logic        req_is_wr,
  output logic [23:0] req_addr,
  output logic [7:0]  req_data,
  output logic        ovr
);

  logic        accept_rd;
  logic        accept_wr;
  logic        accept;
  logic        pend_valid;
  logic        pend_is_wr;
  logic [23:0] pend_addr;
  logic [7:0]  pend_data;

  assign accept_rd = rd_start & rom_hit;
  assign accept_wr = wr_start & ~rd_start & rom_hit & is_writable;
  assign accept    = accept_rd | accept_wr;

  assign req_valid = pend_valid | accept;
  assign req_is_wr = pend_valid ? pend_is_wr : accept_wr;
  assign req_addr  = pend_valid ? pend_addr  : addr;
  assign req_data  = pend_valid ? pend_data  : din;

  // Latch accepted pulses, release on consume, pulse ovr when unserved data is replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_is_wr <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      ovr        <= 1'b0;
    end else begin
      ovr <= accept & pend_valid & ~consume;
      if (accept && !(consume && !pend_valid)) begin
        pend_valid <= 1'b1;
        pend_is_wr <= accept_wr;
        pend_addr  <= addr;
        pend_data  <= din;
      end else if (consume) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rom_access_sequencer.sv
// Runs the physical read/write cycles on the 16-bit external ROM/SRAM for SNES
// and MCU requests, SNES first. All memory pins come straight from flops; the
// next-state logic computes the values they take on the following edge.
module rom_access_sequencer
  import rom_access_sequencer_pkg::*;
#(
  parameter int RD_CYCLES      = RD_CYCLES_DEF,
  parameter int WR_CYCLES      = WR_CYCLES_DEF,
  parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  rom_access_sequencer_if.slave bus
);

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        hold, hold_d;
  logic        consume;

  logic        req_valid;
  logic        req_is_wr;
  logic [23:0] req_addr;
  logic [7:0]  req_data;
  logic        ovr;

  logic [22:0] mem_addr_q, addr_d;
  logic        lane_q, lane_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        bhe_n_q, bhe_n_d;
  logic        ble_n_q, ble_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic [7:0]  snes_dout_q, snes_dout_d;
  logic        valid_q, valid_d;
  logic [7:0]  mcu_din_q, mcu_din_d;
  logic        rdy_q, rdy_d;

  rom_access_sequencer_pending_slot u_slot (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_start    (bus.snes_rd_start),
    .wr_start    (bus.snes_wr_start),
    .addr        (bus.rom_addr),
    .din         (bus.snes_din),
    .rom_hit     (bus.rom_hit),
    .is_writable (bus.is_writable),
    .consume     (consume),
    .req_valid   (req_valid),
    .req_is_wr   (req_is_wr),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .ovr         (ovr)
  );

  // Next state, cycle counter and next values of every registered output.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    hold_d      = hold;
    consume     = 1'b0;
    addr_d      = mem_addr_q;
    lane_d      = lane_q;
    dq_out_d    = dq_out_q;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    snes_dout_d = snes_dout_q;
    valid_d     = 1'b0;
    mcu_din_d   = mcu_din_q;
    rdy_d       = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          consume = 1'b1;
          addr_d  = req_addr[23:1];
          lane_d  = req_addr[0];
          ce_n_d  = 1'b0;
          if (req_is_wr) begin
            state_d  = SWR;
            cnt_d    = 4'(WR_CYCLES);
            dq_out_d = {req_data, req_data};
            we_n_d   = 1'b0;
            dq_oe_d  = 1'b1;
          end else begin
            state_d = SRD;
            cnt_d   = 4'(RD_CYCLES);
            oe_n_d  = 1'b0;
          end
        end else if (bus.mcu_rrq) begin
          state_d = MRD;
          cnt_d   = 4'(RD_CYCLES);
          addr_d  = bus.mcu_addr[23:1];
          lane_d  = bus.mcu_addr[0];
          ce_n_d  = 1'b0;
          oe_n_d  = 1'b0;
        end else if (bus.mcu_wrq) begin
          state_d  = MWR;
          cnt_d    = 4'(WR_CYCLES);
          addr_d   = bus.mcu_addr[23:1];
          lane_d   = bus.mcu_addr[0];
          dq_out_d = {bus.mcu_dout, bus.mcu_dout};
          ce_n_d   = 1'b0;
          we_n_d   = 1'b0;
          dq_oe_d  = 1'b1;
        end
      end

      SRD, MRD: begin
        if (cnt == 4'd1) begin
          state_d = REC;
          cnt_d   = 4'(RECOVER_CYCLES);
          if (state == SRD) begin
            snes_dout_d = lane_byte(lane_q, bus.mem_dq_in);
            valid_d     = 1'b1;
          end else begin
            mcu_din_d = lane_byte(lane_q, bus.mem_dq_in);
            rdy_d     = 1'b1;
          end
        end else begin
          cnt_d  = cnt - 4'd1;
          ce_n_d = 1'b0;
          oe_n_d = 1'b0;
        end
      end

      SWR, MWR: begin
        if (hold) begin
          hold_d  = 1'b0;
          state_d = REC;
          cnt_d   = 4'(RECOVER_CYCLES);
        end else begin
          ce_n_d  = 1'b0;
          dq_oe_d = 1'b1;
          if (cnt == 4'd1) begin
            hold_d = 1'b1;
            rdy_d  = (state == MWR);
          end else begin
            cnt_d  = cnt - 4'd1;
            we_n_d = 1'b0;
          end
        end
      end

      REC: begin
        if (cnt == 4'd1) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    bhe_n_d = ce_n_d | (lane_d != LANE_HIGH);
    ble_n_d = ce_n_d | (lane_d != LANE_LOW);
  end

  // State register plus output flops; reset parks the pins in the idle level at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hold        <= 1'b0;
      mem_addr_q  <= '0;
      lane_q      <= LANE_HIGH;
      dq_out_q    <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      bhe_n_q     <= 1'b1;
      ble_n_q     <= 1'b1;
      dq_oe_q     <= 1'b0;
      snes_dout_q <= '0;
      valid_q     <= 1'b0;
      mcu_din_q   <= '0;
      rdy_q       <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      hold        <= hold_d;
      mem_addr_q  <= addr_d;
      lane_q      <= lane_d;
      dq_out_q    <= dq_out_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      bhe_n_q     <= bhe_n_d;
      ble_n_q     <= ble_n_d;
      dq_oe_q     <= dq_oe_d;
      snes_dout_q <= snes_dout_d;
      valid_q     <= valid_d;
      mcu_din_q   <= mcu_din_d;
      rdy_q       <= rdy_d;
    end
  end

  assign bus.snes_dout       = snes_dout_q;
  assign bus.snes_dout_valid = valid_q;
  assign bus.snes_ovr        = ovr;
  assign bus.mcu_din         = mcu_din_q;
  assign bus.mcu_rdy         = rdy_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_ce_n        = ce_n_q;
  assign bus.mem_oe_n        = oe_n_q;
  assign bus.mem_we_n        = we_n_q;
  assign bus.mem_bhe_n       = bhe_n_q;
  assign bus.mem_ble_n       = ble_n_q;
  assign bus.mem_dq_out      = dq_out_q;
  assign bus.mem_dq_oe       = dq_oe_q;

endmodule

// File: tb/tb_rom_access_sequencer.sv
// Directed bench for the ROM access sequencer: read bytes go into scoreboard
// queues when a request is issued and are compared when VALID/RDY appear.
module tb_rom_access_sequencer;

  logic clk;
  logic rst_n;

  rom_access_sequencer_if bus ();

  rom_access_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks;
  int errors;
  int cyc;
  int valid_cnt, rdy_cnt, ovr_cnt, oe_cnt, we_cnt, dqoe_cnt, ce_cnt;
  int last_valid_cyc, last_rdy_cyc;
  logic [22:0] last_addr;
  logic        last_bhe_n, last_ble_n;
  logic [15:0] last_dq_out;
  logic [7:0]  snes_q[$];
  logic [7:0]  mcu_q[$];

  int s_valid, s_rdy, s_ovr, s_oe, s_we, s_dqoe, s_ce, t0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, score outputs, play the MCU handshake.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.snes_dout_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      if (snes_q.size() == 0) check_output("snes_unexpected_valid", bus.snes_dout_valid, 0);
      else check_output("snes_dout", bus.snes_dout, snes_q.pop_front());
    end
    if (bus.mcu_rdy) begin
      rdy_cnt++;
      last_rdy_cyc = cyc;
      if (mcu_q.size() != 0) check_output("mcu_din", bus.mcu_din, mcu_q.pop_front());
      bus.mcu_rrq = 1'b0;
      bus.mcu_wrq = 1'b0;
    end
    if (bus.snes_ovr) ovr_cnt++;
    if (!bus.mem_oe_n) oe_cnt++;
    if (bus.mem_dq_oe) dqoe_cnt++;
    if (!bus.mem_we_n) begin
      we_cnt++;
      last_dq_out = bus.mem_dq_out;
    end
    if (!bus.mem_ce_n) begin
      ce_cnt++;
      last_addr  = bus.mem_addr;
      last_bhe_n = bus.mem_bhe_n;
      last_ble_n = bus.mem_ble_n;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic apply_stimulus(input bit is_wr, input logic [23:0] addr, input logic [7:0] din,
                                input bit hit, input bit writable);
    bus.snes_rd_start = !is_wr;
    bus.snes_wr_start = is_wr;
    bus.rom_addr      = addr;
    bus.snes_din      = din;
    bus.rom_hit       = hit;
    bus.is_writable   = writable;
    step();
    bus.snes_rd_start = 1'b0;
    bus.snes_wr_start = 1'b0;
  endtask

  task automatic snapshot();
    s_valid = valid_cnt; s_rdy = rdy_cnt; s_ovr = ovr_cnt; s_oe = oe_cnt;
    s_we = we_cnt; s_dqoe = dqoe_cnt; s_ce = ce_cnt; t0 = cyc;
  endtask

  // Directed sequence of all scenarios.
  initial begin
    checks = 0; errors = 0; cyc = 0;
    valid_cnt = 0; rdy_cnt = 0; ovr_cnt = 0; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0; ce_cnt = 0;
    last_valid_cyc = 0; last_rdy_cyc = 0;
    last_addr = '0; last_bhe_n = 1'b1; last_ble_n = 1'b1; last_dq_out = '0;
    rst_n = 1'b0;
    bus.snes_rd_start = 1'b0; bus.snes_wr_start = 1'b0;
    bus.rom_addr = '0; bus.rom_hit = 1'b0; bus.is_writable = 1'b0; bus.snes_din = '0;
    bus.mcu_rrq = 1'b0; bus.mcu_wrq = 1'b0; bus.mcu_addr = '0; bus.mcu_dout = '0;
    bus.mem_dq_in = '0;

    steps(3);
    check_output("rst_ce_n", bus.mem_ce_n, 1);
    check_output("rst_oe_we_n", {bus.mem_oe_n, bus.mem_we_n}, 2'b11);
    check_output("rst_lanes_n", {bus.mem_bhe_n, bus.mem_ble_n}, 2'b11);
    check_output("rst_dq_oe", bus.mem_dq_oe, 0);
    check_output("rst_pulses", {bus.snes_dout_valid, bus.snes_ovr, bus.mcu_rdy}, 3'b000);
    check_output("rst_mem_addr", bus.mem_addr, 0);
    rst_n = 1'b1;
    steps(2);

    $display("[TB] snes read, odd byte");
    bus.mem_dq_in = 16'hA55A;
    snes_q.push_back(8'h5A);
    snapshot();
    apply_stimulus(0, 24'h008001, 8'h00, 1, 0);
    steps(11);
    check_output("rd_latency", last_valid_cyc - t0, 6);
    check_output("rd_oe_clocks", oe_cnt - s_oe, 5);
    check_output("rd_mem_addr", last_addr, 23'h004000);
    check_output("rd_lanes_n", {last_bhe_n, last_ble_n}, 2'b10);
    check_output("rd_valid_count", valid_cnt - s_valid, 1);

    $display("[TB] snes write, even byte");
    snapshot();
    apply_stimulus(1, 24'hE00010, 8'h3C, 1, 1);
    steps(11);
    check_output("wr_we_clocks", we_cnt - s_we, 4);
    check_output("wr_dq_oe_clocks", dqoe_cnt - s_dqoe, 5);
    check_output("wr_dq_out", last_dq_out, 16'h3C3C);
    check_output("wr_mem_addr", last_addr, 23'h700008);
    check_output("wr_lanes_n", {last_bhe_n, last_ble_n}, 2'b01);
    check_output("wr_no_oe", oe_cnt - s_oe, 0);

    $display("[TB] rejected requests");
    snapshot();
    apply_stimulus(1, 24'hE00010, 8'h3C, 1, 0);
    steps(8);
    apply_stimulus(0, 24'h008001, 8'h00, 0, 0);
    steps(8);
    check_output("reject_ce_clocks", ce_cnt - s_ce, 0);
    check_output("reject_valid", valid_cnt - s_valid, 0);

    $display("[TB] same-clock snes and mcu read");
    bus.mem_dq_in = 16'hBEEF;
    snes_q.push_back(8'hBE);
    mcu_q.push_back(8'hEF);
    bus.mcu_addr = 24'h000203;
    bus.mcu_rrq  = 1'b1;
    snapshot();
    apply_stimulus(0, 24'h000100, 8'h00, 1, 0);
    steps(20);
    check_output("cont_rdy_count", rdy_cnt - s_rdy, 1);
    check_output("cont_valid_count", valid_cnt - s_valid, 1);
    check_output("cont_snes_first", last_valid_cyc < last_rdy_cyc, 1);

    $display("[TB] snes read during mcu write");
    bus.mem_dq_in = 16'h1234;
    snes_q.push_back(8'h34);
    bus.mcu_addr = 24'h000010;
    bus.mcu_dout = 8'h77;
    bus.mcu_wrq  = 1'b1;
    snapshot();
    steps(3);
    apply_stimulus(0, 24'h000021, 8'h00, 1, 0);
    steps(20);
    check_output("mwr_rdy_count", rdy_cnt - s_rdy, 1);
    check_output("mwr_we_clocks", we_cnt - s_we, 4);
    check_output("mwr_no_ovr", ovr_cnt - s_ovr, 0);
    check_output("mwr_snes_after", last_valid_cyc > last_rdy_cyc, 1);
    check_output("mwr_valid_count", valid_cnt - s_valid, 1);

    $display("[TB] overrun during mcu read");
    bus.mem_dq_in = 16'hCAFE;
    mcu_q.push_back(8'hCA);
    snes_q.push_back(8'hFE);
    bus.mcu_addr = 24'h000300;
    bus.mcu_rrq  = 1'b1;
    snapshot();
    step();
    apply_stimulus(0, 24'h000400, 8'h00, 1, 0);
    step();
    apply_stimulus(0, 24'h000501, 8'h00, 1, 0);
    steps(25);
    check_output("ovr_count", ovr_cnt - s_ovr, 1);
    check_output("ovr_valid_count", valid_cnt - s_valid, 1);
    check_output("ovr_rdy_count", rdy_cnt - s_rdy, 1);
    check_output("ovr_mem_addr", last_addr, 23'h000280);

    $display("[TB] reset in the middle of a snes read");
    bus.mem_dq_in = 16'h5566;
    snapshot();
    apply_stimulus(0, 24'h000600, 8'h00, 1, 0);
    steps(2);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_strobes_n", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_bhe_n}, 3'b111);
    steps(4);
    rst_n = 1'b1;
    steps(4);
    check_output("mid_rst_no_valid", valid_cnt - s_valid, 0);
    snes_q.push_back(8'h55);
    snapshot();
    apply_stimulus(0, 24'h000600, 8'h00, 1, 0);
    steps(11);
    check_output("post_rst_valid", valid_cnt - s_valid, 1);
    check_output("post_rst_latency", last_valid_cyc - t0, 6);

    check_output("snes_queue_drained", snes_q.size(), 0);
    check_output("mcu_queue_drained", mcu_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
